pipelined_datapath: RTL and testbench
=====================================

// Module: pipelined_datapath
// PURPOSE
//  Five-stage (IF/ID/EX/MEM/WB) MIPS-subset datapath. Next generation of the single-cycle datapath.
//  Parametrised width and register count; internal register file, forwarding and hazard handling.
//  Memory interfaces are external ports; the controller decodes instr_id and returns control in ID.
// PARAMETERS
//  DATA_W      32  datapath / register / memory-word width
//  REG_AW      5   register-address width; 2**REG_AW registers, r0 hardwired to 0
//  PC_RESET    0   PC value loaded on reset
//  FORWARDING  1   1: EX/MEM and MEM/WB bypass to EX; 0: stall until the producer writes back
// PORTS
//  clk          in   1       clock
//  reset        in   1       reset, synchronous, active-low
//  pc           out  DATA_W  IF-stage PC, drives instruction memory address
//  imem_data    in   32      instruction at pc, combinational
//  instr_id     out  32      IF/ID instruction, to controller
//  Mem2reg, Memwrite, Branch, ALUSrc, Regdst, Regwrite, Sgnzero  in 1 each  ID-stage control
//  ALUOP        in   3       000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed); others -> 0
//  dmem_addr    out  DATA_W  EX/MEM ALU result
//  dmem_wdata   out  DATA_W  EX/MEM store data (forwarded rt)
//  dmem_we      out  1       store in MEM stage
//  dmem_re      out  1       load in MEM stage
//  dmem_rdata   in   DATA_W  load data, valid when dmem_ready=1
//  dmem_ready   in   1       memory handshake; ignored when dmem_we=dmem_re=0
//  stall        out  1       load-use or memory freeze active this cycle
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - pc=PC_RESET; all pipeline regs invalid/NOP; all control bits cleared.
//   - dmem_we=dmem_re=0; stall=0; register file cleared to 0.
//   - Reset overrides every stall, flush and memory wait in progress.
//  Immediates: Sgnzero=1 sign-extends imm[15:0] to DATA_W, else zero-extends.
//   Branch offset = ext << 2. Arithmetic mod 2**DATA_W; no overflow flag.
//  Register file: 2 async reads, 1 write at posedge in WB.
//   Same-cycle WB->ID bypass. Writes to r0 discarded.
//  Write data selection: Mem2reg ? load data : ALU result. Destination: Regdst ? rd : rt.
//  Forwarding (FORWARDING=1), per EX operand:
//   - Priority EX/MEM (Regwrite & !Mem2reg & dst==src & dst!=0), then MEM/WB, then register file.
//  Load-use hazard: ID/EX is a load, its dst!=0 and equals ID rs or rt.
//   - pc and IF/ID hold; a NOP enters ID/EX; stall=1 for exactly 1 cycle.
//   - FORWARDING=0: any RAW hazard stalls the same way until the producer reaches WB.
//  Branch: beq resolved in EX; taken = Branch & (rs==rt).
//   - pc <= PC_EX+4+off; IF/ID and ID/EX flushed to NOP; 2-cycle penalty; no register/memory effect.
//  Memory wait: MEM holds a load/store and dmem_ready=0.
//   - pc, IF/ID, ID/EX, EX/MEM frozen; NOP into MEM/WB; dmem_* held stable; stall=1.
//   - Store takes effect once, in the cycle with dmem_ready=1.
//  Simultaneous events:
//   - Memory freeze beats taken branch; the redirect applies on the release cycle.
//   - Taken branch beats load-use; the flushed instruction does not stall.
//  Latency: 5 cycles fetch-to-writeback, CPI 1 without hazards.
//  pc wraps modulo 2**DATA_W.
// TESTING
//  1. reset=0 for 2 cycles, then 1 -> pc 0,4,8,12; dmem_we=0 throughout reset.
//  2. addi r1,r0,5; add r2,r1,r1; sub r3,r2,r1 -> r2=10, r3=5, stall never 1 (FORWARDING=1).
//  3. mem[0]=7; lw r3,0(r0); add r4,r3,r3 -> stall=1 for exactly one cycle, r4=14.
//  4. beq r0,r0,+2 at pc=8 -> following fetches 12,16 flushed, next pc=20, no writes from 12/16.
//  5. sw r1,4(r0) with dmem_ready=0 for 3 cycles -> pc holds 3 cycles, dmem_we held, mem[4]=5 once.
//  6. reset=0 during case-5 wait -> next edge pc=PC_RESET, dmem_we=0, stall=0, regs=0.

Source files
------------

// File: rtl/pipelined_datapath.sv
// pipelined_datapath
//   Five-stage (IF/ID/EX/MEM/WB) MIPS-subset datapath with an internal
//   register file, EX-stage forwarding, load-use / RAW interlocks, beq
//   resolved in EX and a memory-wait freeze. Instruction decode lives in an
//   external controller that sees instr_id and answers with ID-stage control.
// Ports
//   clk, reset          clock; synchronous active-low reset
//   pc                  IF-stage PC (instruction memory address)
//   imem_data           instruction at pc (combinational)
//   instr_id            IF/ID instruction, to the controller
//   Mem2reg..Sgnzero    ID-stage control bits from the controller
//   ALUOP               000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others -> 0
//   dmem_addr/wdata     EX/MEM ALU result / store data
//   dmem_we/dmem_re     store / load in MEM stage
//   dmem_rdata          load data
//   dmem_ready          memory handshake
//   stall               load-use, RAW or memory freeze active this cycle
module pipelined_datapath #(
  parameter int                DATA_W     = 32,
  parameter int                REG_AW     = 5,
  parameter logic [DATA_W-1:0] PC_RESET   = '0,
  parameter int                FORWARDING = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] pc,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instr_id,
  input  logic              Mem2reg,
  input  logic              Memwrite,
  input  logic              Branch,
  input  logic              ALUSrc,
  input  logic              Regdst,
  input  logic              Regwrite,
  input  logic              Sgnzero,
  input  logic [2:0]        ALUOP,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall
);
  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] rf [NREG];

  // IF/ID
  logic              ifid_valid;
  logic [31:0]       ifid_instr;
  logic [DATA_W-1:0] ifid_pc4;
  // ID/EX
  logic              idex_valid, idex_mem2reg, idex_memwrite, idex_branch;
  logic              idex_alusrc, idex_regwrite;
  logic [2:0]        idex_aluop;
  logic [REG_AW-1:0] idex_rs, idex_rt, idex_dst;
  logic [DATA_W-1:0] idex_a, idex_b, idex_imm, idex_pc4;
  // EX/MEM
  logic              exmem_valid, exmem_mem2reg, exmem_memwrite, exmem_regwrite;
  logic [REG_AW-1:0] exmem_dst;
  logic [DATA_W-1:0] exmem_alu, exmem_wdata;
  // MEM/WB
  logic              memwb_valid, memwb_mem2reg, memwb_regwrite;
  logic [REG_AW-1:0] memwb_dst;
  logic [DATA_W-1:0] memwb_alu, memwb_rdata;

  // ---------------- ID ----------------
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_imm, id_a, id_b, wb_data;
  logic              wb_we;

  assign instr_id = ifid_instr;
  assign id_rs    = ifid_instr[21 +: REG_AW];
  assign id_rt    = ifid_instr[16 +: REG_AW];
  assign id_rd    = ifid_instr[11 +: REG_AW];
  assign id_imm   = Sgnzero ? {{(DATA_W-16){ifid_instr[15]}}, ifid_instr[15:0]}
                            : {{(DATA_W-16){1'b0}}, ifid_instr[15:0]};

  assign wb_we   = memwb_valid & memwb_regwrite & (memwb_dst != '0);
  assign wb_data = memwb_mem2reg ? memwb_rdata : memwb_alu;

  // Register read with same-cycle write-back bypass; r0 always reads 0.
  assign id_a = (id_rs == '0) ? '0 : (wb_we && memwb_dst == id_rs) ? wb_data : rf[id_rs];
  assign id_b = (id_rt == '0) ? '0 : (wb_we && memwb_dst == id_rt) ? wb_data : rf[id_rt];

  // ---------------- EX ----------------
  logic [DATA_W-1:0] ex_a, ex_b, alu_b, alu_y, br_target;
  logic              exmem_fwd_ok, br_taken;

  // Loads in EX/MEM have no data yet; the load-use interlock covers them.
  assign exmem_fwd_ok = exmem_valid & exmem_regwrite & ~exmem_mem2reg & (exmem_dst != '0);

  always_comb begin
    ex_a = idex_a;
    ex_b = idex_b;
    if (FORWARDING != 0) begin
      if (exmem_fwd_ok && exmem_dst == idex_rs)   ex_a = exmem_alu;
      else if (wb_we && memwb_dst == idex_rs)     ex_a = wb_data;
      if (exmem_fwd_ok && exmem_dst == idex_rt)   ex_b = exmem_alu;
      else if (wb_we && memwb_dst == idex_rt)     ex_b = wb_data;
    end
  end

  assign alu_b = idex_alusrc ? idex_imm : ex_b;

  always_comb begin
    case (idex_aluop)
      3'b000:  alu_y = ex_a & alu_b;
      3'b001:  alu_y = ex_a | alu_b;
      3'b010:  alu_y = ex_a + alu_b;
      3'b110:  alu_y = ex_a - alu_b;
      3'b111:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(alu_b))};
      default: alu_y = '0;
    endcase
  end

  assign br_taken  = idex_valid & idex_branch & (ex_a == ex_b);
  assign br_target = idex_pc4 + (idex_imm << 2);

  // ---------------- hazards ----------------
  // Memory handshake: while MEM holds a load or store, the access completes
  // in the cycle dmem_ready=1; until then dmem_* stay stable and everything
  // up to EX/MEM freezes. dmem_ready is don't-care when no access is pending.
  logic mem_wait, hit_idex, hit_exmem, raw, hazard, id_ok;

  assign mem_wait  = exmem_valid & (exmem_mem2reg | exmem_memwrite) & ~dmem_ready;
  assign hit_idex  = idex_valid & idex_regwrite & (idex_dst != '0) &
                     ((idex_dst == id_rs) | (idex_dst == id_rt));
  assign hit_exmem = exmem_valid & exmem_regwrite & (exmem_dst != '0) &
                     ((exmem_dst == id_rs) | (exmem_dst == id_rt));
  assign raw       = ifid_valid & ((FORWARDING != 0) ? (hit_idex & idex_mem2reg)
                                                     : (hit_idex | hit_exmem));
  // A taken branch flushes the ID instruction, so it never stalls.
  assign hazard    = raw & ~br_taken;
  assign id_ok     = ifid_valid & ~hazard & ~br_taken;
  assign stall     = mem_wait | hazard;

  assign dmem_addr  = exmem_alu;
  assign dmem_wdata = exmem_wdata;
  assign dmem_we    = exmem_valid & exmem_memwrite;
  assign dmem_re    = exmem_valid & exmem_mem2reg;

  // ---------------- register file ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[memwb_dst] <= wb_data;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc             <= PC_RESET;
      ifid_valid     <= 1'b0;
      ifid_instr     <= '0;
      ifid_pc4       <= '0;
      idex_valid     <= 1'b0;
      idex_mem2reg   <= 1'b0;
      idex_memwrite  <= 1'b0;
      idex_branch    <= 1'b0;
      idex_alusrc    <= 1'b0;
      idex_regwrite  <= 1'b0;
      idex_aluop     <= '0;
      idex_rs        <= '0;
      idex_rt        <= '0;
      idex_dst       <= '0;
      idex_a         <= '0;
      idex_b         <= '0;
      idex_imm       <= '0;
      idex_pc4       <= '0;
      exmem_valid    <= 1'b0;
      exmem_mem2reg  <= 1'b0;
      exmem_memwrite <= 1'b0;
      exmem_regwrite <= 1'b0;
      exmem_dst      <= '0;
      exmem_alu      <= '0;
      exmem_wdata    <= '0;
      memwb_valid    <= 1'b0;
      memwb_mem2reg  <= 1'b0;
      memwb_regwrite <= 1'b0;
      memwb_dst      <= '0;
      memwb_alu      <= '0;
      memwb_rdata    <= '0;
    end else if (mem_wait) begin
      // The frozen EX instruction may lose its MEM/WB bypass source once that
      // instruction retires, so capture the currently forwarded operands.
      idex_a         <= ex_a;
      idex_b         <= ex_b;
      memwb_valid    <= 1'b0;
      memwb_regwrite <= 1'b0;
      memwb_mem2reg  <= 1'b0;
    end else begin
      memwb_valid    <= exmem_valid;
      memwb_mem2reg  <= exmem_mem2reg;
      memwb_regwrite <= exmem_regwrite;
      memwb_dst      <= exmem_dst;
      memwb_alu      <= exmem_alu;
      memwb_rdata    <= dmem_rdata;

      exmem_valid    <= idex_valid;
      exmem_mem2reg  <= idex_mem2reg;
      exmem_memwrite <= idex_memwrite;
      exmem_regwrite <= idex_regwrite;
      exmem_dst      <= idex_dst;
      exmem_alu      <= alu_y;
      exmem_wdata    <= ex_b;

      // ID/EX takes the decoded instruction or a bubble (stall / flush).
      idex_valid     <= id_ok;
      idex_mem2reg   <= id_ok & Mem2reg;
      idex_memwrite  <= id_ok & Memwrite;
      idex_branch    <= id_ok & Branch;
      idex_alusrc    <= id_ok & ALUSrc;
      idex_regwrite  <= id_ok & Regwrite;
      idex_aluop     <= ALUOP;
      idex_rs        <= id_rs;
      idex_rt        <= id_rt;
      idex_dst       <= Regdst ? id_rd : id_rt;
      idex_a         <= id_a;
      idex_b         <= id_b;
      idex_imm       <= id_imm;
      idex_pc4       <= ifid_pc4;

      if (br_taken) begin
        pc         <= br_target;
        ifid_valid <= 1'b0;
        ifid_instr <= '0;
      end else if (!hazard) begin
        pc         <= pc + DATA_W'(4);
        ifid_valid <= 1'b1;
        ifid_instr <= imem_data;
        ifid_pc4   <= pc + DATA_W'(4);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
// tb_pipelined_datapath
//   Directed tests for pipelined_datapath: reset, forwarding, ALU ops,
//   load-use interlock, taken branch, memory wait and reset during a wait.
//   The bench provides instruction/data memories and the controller decode.
module tb_pipelined_datapath;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] pc;
  logic [31:0]       imem_data, instr_id;
  logic              Mem2reg, Memwrite, Branch, ALUSrc, Regdst, Regwrite, Sgnzero;
  logic [2:0]        ALUOP;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic              dmem_we, dmem_re, dmem_ready;
  logic              stall;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic        ready_drv;

  logic [31:0] st_addr_q[$], st_data_q[$];
  logic [31:0] exp_q[$], exp_addr_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          stall_cnt;

  always #5 clk = ~clk;

  pipelined_datapath #(.DATA_W(DATA_W), .REG_AW(5), .PC_RESET('0), .FORWARDING(1)) dut (
    .clk(clk), .reset(reset), .pc(pc), .imem_data(imem_data), .instr_id(instr_id),
    .Mem2reg(Mem2reg), .Memwrite(Memwrite), .Branch(Branch), .ALUSrc(ALUSrc),
    .Regdst(Regdst), .Regwrite(Regwrite), .Sgnzero(Sgnzero), .ALUOP(ALUOP),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .stall(stall)
  );

  assign imem_data  = (pc[31:8] == '0) ? imem[pc[7:2]] : 32'h0;
  assign dmem_rdata = dmem[dmem_addr[7:2]];
  assign dmem_ready = ready_drv;

  // Controller: decodes instr_id into ID-stage control.
  always_comb begin
    Mem2reg = 0; Memwrite = 0; Branch = 0; ALUSrc = 0;
    Regdst = 0; Regwrite = 0; Sgnzero = 0; ALUOP = 3'b000;
    case (instr_id[31:26])
      6'h00: begin
        Regdst = 1; Regwrite = 1;
        case (instr_id[5:0])
          6'h20:   ALUOP = 3'b010;
          6'h22:   ALUOP = 3'b110;
          6'h24:   ALUOP = 3'b000;
          6'h25:   ALUOP = 3'b001;
          6'h2a:   ALUOP = 3'b111;
          default: Regwrite = 0;
        endcase
      end
      6'h08: begin Regwrite = 1; ALUSrc = 1; Sgnzero = 1; ALUOP = 3'b010; end
      6'h0d: begin Regwrite = 1; ALUSrc = 1; ALUOP = 3'b001; end
      6'h23: begin Mem2reg = 1; Regwrite = 1; ALUSrc = 1; Sgnzero = 1; ALUOP = 3'b010; end
      6'h2b: begin Memwrite = 1; ALUSrc = 1; Sgnzero = 1; ALUOP = 3'b010; end
      6'h04: begin Branch = 1; Sgnzero = 1; ALUOP = 3'b110; end
      default: ;
    endcase
  end

  // Data memory and store log.
  always @(posedge clk) begin
    if (reset && dmem_we && dmem_ready) begin
      dmem[dmem_addr[7:2]] <= dmem_wdata;
      st_addr_q.push_back(dmem_addr);
      st_data_q.push_back(dmem_wdata);
    end
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    ready_drv = 1'b1;
    repeat (2) @(negedge clk);
    st_addr_q.delete();
    st_data_q.delete();
    stall_cnt = 0;
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (stall) stall_cnt++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_mem();
    @(negedge clk);
    reset = 1'b0;
    ready_drv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", pc); end
      n_cmp++;
      if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", dmem_we); end
      n_cmp++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    end
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (pc !== 32'(4 * k)) begin
        n_fail++; $display("FAIL fetch_pc%0d: got %0h expected %0h", k, pc, 4 * k);
      end
    end
  endtask

  task automatic test_forwarding();
    clear_mem();
    imem[0] = itype(6'h08, 0, 1, 16'd5);     // addi r1,r0,5
    imem[1] = rtype(1, 1, 2, 6'h20);         // add  r2,r1,r1
    imem[2] = rtype(2, 1, 3, 6'h22);         // sub  r3,r2,r1
    imem[3] = itype(6'h2b, 0, 2, 16'd0);     // sw   r2,0(r0)
    imem[4] = itype(6'h2b, 0, 3, 16'd4);     // sw   r3,4(r0)
    exp_addr_q = '{32'd0, 32'd4};
    exp_q      = '{32'd10, 32'd5};
    do_reset();
    run(15);
    n_cmp++;
    if (stall_cnt !== 0) begin n_fail++; $display("FAIL fwd_stalls: got %0d expected 0", stall_cnt); end
    n_cmp++;
    if (pc !== 32'd60) begin n_fail++; $display("FAIL fwd_pc: got %0h expected 3c", pc); end
    n_cmp++;
    if (st_data_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL fwd_nstores: got %0d expected %0d", st_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < st_data_q.size(); i++) begin
      n_cmp++;
      if (st_addr_q[i] !== exp_addr_q[i] || st_data_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fwd_store%0d: got %0h@%0h expected %0h@%0h", i, st_data_q[i],
                 st_addr_q[i], exp_q[i], exp_addr_q[i]);
      end
    end
  endtask

  task automatic test_alu_ops();
    clear_mem();
    imem[0]  = itype(6'h08, 0, 1, 16'hfffd);  // addi r1,r0,-3
    imem[1]  = itype(6'h08, 0, 2, 16'd6);     // addi r2,r0,6
    imem[2]  = rtype(1, 2, 3, 6'h2a);         // slt  r3,r1,r2
    imem[3]  = rtype(1, 2, 4, 6'h24);         // and  r4,r1,r2
    imem[4]  = rtype(1, 2, 5, 6'h25);         // or   r5,r1,r2
    imem[5]  = rtype(2, 1, 6, 6'h2a);         // slt  r6,r2,r1
    imem[6]  = itype(6'h2b, 0, 3, 16'd0);
    imem[7]  = itype(6'h2b, 0, 4, 16'd4);
    imem[8]  = itype(6'h2b, 0, 5, 16'd8);
    imem[9]  = itype(6'h2b, 0, 6, 16'd12);
    imem[10] = itype(6'h0d, 0, 7, 16'h8000);  // ori  r7,r0,0x8000 (zero-extended)
    imem[11] = itype(6'h2b, 0, 7, 16'd16);
    exp_addr_q = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};
    exp_q      = '{32'd1, 32'd4, 32'hffffffff, 32'd0, 32'h00008000};
    do_reset();
    run(20);
    n_cmp++;
    if (st_data_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL alu_nstores: got %0d expected %0d", st_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < st_data_q.size(); i++) begin
      n_cmp++;
      if (st_addr_q[i] !== exp_addr_q[i] || st_data_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL alu_store%0d: got %0h@%0h expected %0h@%0h", i, st_data_q[i],
                 st_addr_q[i], exp_q[i], exp_addr_q[i]);
      end
    end
  endtask

  task automatic test_load_use();
    clear_mem();
    dmem[0] = 32'd7;
    imem[0] = itype(6'h23, 0, 3, 16'd0);     // lw  r3,0(r0)
    imem[1] = rtype(3, 3, 4, 6'h20);         // add r4,r3,r3
    imem[2] = itype(6'h2b, 0, 4, 16'd8);     // sw  r4,8(r0)
    do_reset();
    run(15);
    n_cmp++;
    if (stall_cnt !== 1) begin n_fail++; $display("FAIL lu_stalls: got %0d expected 1", stall_cnt); end
    n_cmp++;
    if (pc !== 32'd56) begin n_fail++; $display("FAIL lu_pc: got %0h expected 38", pc); end
    n_cmp++;
    if (st_data_q.size() != 1) begin
      n_fail++; $display("FAIL lu_nstores: got %0d expected 1", st_data_q.size());
    end else begin
      n_cmp++;
      if (st_addr_q[0] !== 32'd8 || st_data_q[0] !== 32'd14) begin
        n_fail++; $display("FAIL lu_store: got %0h@%0h expected e@8", st_data_q[0], st_addr_q[0]);
      end
    end
  endtask

  task automatic test_branch();
    clear_mem();
    imem[0] = itype(6'h08, 0, 1, 16'd1);     // addi r1,r0,1
    imem[1] = itype(6'h08, 0, 2, 16'd2);     // addi r2,r0,2
    imem[2] = itype(6'h04, 0, 0, 16'd2);     // beq  r0,r0,+2 -> 20
    imem[3] = itype(6'h08, 0, 5, 16'd9);     // addi r5,r0,9   (flushed)
    imem[4] = itype(6'h2b, 0, 1, 16'd16);    // sw   r1,16(r0) (flushed)
    imem[5] = itype(6'h2b, 0, 5, 16'd20);    // sw   r5,20(r0)
    imem[6] = itype(6'h2b, 0, 2, 16'd24);    // sw   r2,24(r0)
    exp_addr_q = '{32'd20, 32'd24};
    exp_q      = '{32'd0, 32'd2};
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (c == 4) begin
        n_cmp++;
        if (pc !== 32'd16) begin n_fail++; $display("FAIL br_pc_c4: got %0h expected 10", pc); end
      end
      if (c == 5) begin
        n_cmp++;
        if (pc !== 32'd20) begin n_fail++; $display("FAIL br_target: got %0h expected 14", pc); end
        n_cmp++;
        if (instr_id !== 32'h0) begin n_fail++; $display("FAIL br_flush_id: got %0h expected 0", instr_id); end
      end
    end
    n_cmp++;
    if (stall_cnt !== 0) begin n_fail++; $display("FAIL br_stalls: got %0d expected 0", stall_cnt); end
    n_cmp++;
    if (st_data_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL br_nstores: got %0d expected %0d", st_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < st_data_q.size(); i++) begin
      n_cmp++;
      if (st_addr_q[i] !== exp_addr_q[i] || st_data_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL br_store%0d: got %0h@%0h expected %0h@%0h", i, st_data_q[i],
                 st_addr_q[i], exp_q[i], exp_addr_q[i]);
      end
    end
  endtask

  task automatic load_wait_prog();
    clear_mem();
    imem[0] = itype(6'h08, 0, 1, 16'd5);     // addi r1,r0,5
    imem[1] = itype(6'h2b, 0, 1, 16'd4);     // sw   r1,4(r0)
    imem[2] = itype(6'h08, 0, 6, 16'd3);     // addi r6,r0,3
    imem[3] = itype(6'h2b, 0, 6, 16'd8);     // sw   r6,8(r0)
  endtask

  task automatic wait_for_store(input string tag);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dmem_we) found = 1;
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL %s_we_timeout: got 0 expected 1", tag); end
  endtask

  task automatic test_mem_wait();
    load_wait_prog();
    exp_addr_q = '{32'd4, 32'd8};
    exp_q      = '{32'd5, 32'd3};
    do_reset();
    wait_for_store("mw");
    n_cmp++;
    if (pc !== 32'd16) begin n_fail++; $display("FAIL mw_pc_first: got %0h expected 10", pc); end
    ready_drv = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL mw_stall0: got %b expected 1", stall); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (pc !== 32'd16 || dmem_we !== 1'b1 || stall !== 1'b1 ||
          dmem_addr !== 32'd4 || dmem_wdata !== 32'd5) begin
        n_fail++;
        $display("FAIL mw_hold%0d: got pc=%0h we=%b stall=%b %0h@%0h expected pc=10 we=1 stall=1 5@4",
                 c, pc, dmem_we, stall, dmem_wdata, dmem_addr);
      end
    end
    n_cmp++;
    if (st_data_q.size() != 0) begin
      n_fail++; $display("FAIL mw_early_store: got %0d expected 0", st_data_q.size());
    end
    ready_drv = 1'b1;
    stall_cnt = 0;
    run(12);
    n_cmp++;
    if (pc !== 32'd64) begin n_fail++; $display("FAIL mw_pc_after: got %0h expected 40", pc); end
    n_cmp++;
    if (stall_cnt !== 0) begin n_fail++; $display("FAIL mw_stalls_after: got %0d expected 0", stall_cnt); end
    n_cmp++;
    if (st_data_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL mw_nstores: got %0d expected %0d", st_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < st_data_q.size(); i++) begin
      n_cmp++;
      if (st_addr_q[i] !== exp_addr_q[i] || st_data_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mw_store%0d: got %0h@%0h expected %0h@%0h", i, st_data_q[i],
                 st_addr_q[i], exp_q[i], exp_addr_q[i]);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    load_wait_prog();
    do_reset();
    wait_for_store("rw");
    ready_drv = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    // New program that dumps r1 and r6 once reset releases.
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0] = itype(6'h2b, 0, 1, 16'd0);     // sw r1,0(r0)
    imem[1] = itype(6'h2b, 0, 6, 16'd4);     // sw r6,4(r0)
    @(negedge clk);
    n_cmp++;
    if (pc !== 32'h0 || dmem_we !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_reset_state: got pc=%0h we=%b stall=%b expected pc=0 we=0 stall=0",
               pc, dmem_we, stall);
    end
    n_cmp++;
    if (st_data_q.size() != 0) begin
      n_fail++; $display("FAIL rw_aborted_store: got %0d expected 0", st_data_q.size());
    end
    ready_drv = 1'b1;
    reset = 1'b1;
    exp_addr_q = '{32'd0, 32'd4};
    exp_q      = '{32'd0, 32'd0};
    run(12);
    n_cmp++;
    if (st_data_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rw_nstores: got %0d expected %0d", st_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < st_data_q.size(); i++) begin
      n_cmp++;
      if (st_addr_q[i] !== exp_addr_q[i] || st_data_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rw_regs%0d: got %0h@%0h expected %0h@%0h", i, st_data_q[i],
                 st_addr_q[i], exp_q[i], exp_addr_q[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    ready_drv = 1'b1;
    stall_cnt = 0;
    test_reset();
    test_forwarding();
    test_alu_ops();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
